// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode/code-memory definitions: bubble encoding, reset PC,
// code-memory geometry and instruction field positions.
package instr_fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam int          MEM_DEPTH = 256;
  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [31:0] RESET_PC  = 32'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds; resets to a bubble.
module if_id_reg #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  output logic [31:0]     o_instr,
  output logic [PC_W-1:0] o_pc,
  output logic            o_valid
);
  import instr_fetch_pkg::*;

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic               r_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the word-indexed PC, drives the code memory combinationally
// and loads the IF/ID register; priority is en, then redirect, then stall.
module instr_fetch #(
  parameter int          PC_W      = 32,
  parameter int          MEM_DEPTH = instr_fetch_pkg::MEM_DEPTH,
  parameter logic [31:0] RESET_PC  = instr_fetch_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = instr_fetch_pkg::NOP_INSTR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic [PC_W-1:0] o_mem_pc,
  input  logic [31:0]     i_mem_instr,
  output logic [31:0]     o_id_instr,
  output logic [PC_W-1:0] o_id_pc,
  output logic            o_id_valid,
  output logic [31:0]     o_fetch_count
);
  import instr_fetch_pkg::*;

  // MEM_DEPTH is a power of two, so wrapping is a plain mask.
  localparam logic [PC_W-1:0] PC_MASK = PC_W'(MEM_DEPTH - 1);

  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_fetch_count;
  logic            w_flush;
  logic            w_advance;

  assign w_flush   = i_en & i_redirect;
  assign w_advance = i_en & ~i_redirect & ~i_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= PC_W'(RESET_PC) & PC_MASK;
    end else if (w_flush) begin
      r_pc <= i_redirect_pc & PC_MASK;
    end else if (w_advance) begin
      r_pc <= (r_pc + PC_W'(1)) & PC_MASK;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_count <= 32'd0;
    end else if (w_advance) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  if_id_reg #(
    .PC_W      (PC_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_advance),
    .i_flush (w_flush),
    .i_instr (i_mem_instr),
    .i_pc    (r_pc),
    .o_instr (o_id_instr),
    .o_pc    (o_id_pc),
    .o_valid (o_id_valid)
  );

  assign o_mem_pc      = r_pc;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random control
// traffic, compared against a word-indexed fetch model.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_pc;
  logic [31:0] mem_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];

  int vectors;
  int miscompares;

  // reference state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic        m_valid;
  logic [31:0] m_cnt;

  instr_fetch dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_mem_pc      (mem_pc),
    .i_mem_instr   (mem_instr),
    .o_id_instr    (id_instr),
    .o_id_pc       (id_pc),
    .o_id_valid    (id_valid),
    .o_fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb mem_instr = mem[mem_pc[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".mem_pc"},      mem_pc,             m_pc);
    chk({tag, ".id_instr"},    id_instr,           m_instr);
    chk({tag, ".id_pc"},       id_pc,              m_idpc);
    chk({tag, ".id_valid"},    {31'd0, id_valid},  {31'd0, m_valid});
    chk({tag, ".fetch_count"}, fetch_count,        m_cnt);
    $display("%s: mem_pc=%0d id_pc=%0d id_instr=%h valid=%0b count=%0d",
             tag, mem_pc, id_pc, id_instr, id_valid, fetch_count);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_instr = 32'd0; m_idpc = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
  endtask

  // One clock edge with the given controls; model evaluated from the rules.
  task automatic step(input string tag, input logic e, input logic s,
                      input logic r, input logic [31:0] rpc);
    en = e; stall = s; redirect = r; redirect_pc = rpc;
    @(posedge clk);
    if (e) begin
      if (r) begin
        m_pc = rpc % 256; m_instr = 32'd0; m_idpc = 32'd0; m_valid = 1'b0;
      end else if (!s) begin
        m_instr = mem[m_pc]; m_idpc = m_pc; m_valid = 1'b1;
        m_pc = (m_pc + 1) % 256; m_cnt = m_cnt + 1;
      end
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h44200001; mem[1] = 32'h44400002;
    mem[2] = 32'h44600003; mem[3] = 32'h44800004;
    mem[20] = 32'h0000_0000;

    rst = 1'b1; en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) step("fetch4", 1, 0, 0, 0);
    step("adv_to5", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("stall", 1, 1, 0, 0);
    step("stall_release", 1, 0, 0, 0);
    step("adv_to7", 1, 0, 0, 0);
    step("redir12_stall", 1, 1, 1, 32'd12);
    step("redir12_target", 1, 0, 0, 0);

    step("redir_1fe", 1, 0, 1, 32'h1FE);
    step("wrap_fe", 1, 0, 0, 0);
    step("wrap_ff", 1, 0, 0, 0);

    step("en0_redir_a", 0, 0, 1, 32'd33);
    step("en0_redir_b", 0, 1, 1, 32'd44);

    step("b2b_redir_a", 1, 0, 1, 32'd100);
    step("b2b_redir_b", 1, 0, 1, 32'd20);
    step("zero_word", 1, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      logic e, s, r;
      e = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 6) == 0);
      step("rand", e, s, r, $urandom);
    end

    for (int i = 0; i < 10; i++) step("pre_rst", 1, 0, 0, 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst", 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch-stage initiator for the word-indexed, combinational-read code memory.
- Owns the program counter and drives it as the memory word index (PC advances by 1 per instruction, not 4).
- Captures the returned instruction into the IF/ID pipeline register.
- Honours stall from the hazard unit and redirect (taken branch/jump) from EX. Keeps a count of delivered instructions.

Parameters:
- PC_W, 32, width of PC and of the memory index port.
- MEM_DEPTH, 256, number of code-memory words; must be a power of two. PC wraps modulo MEM_DEPTH.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, bubble encoding placed in IF/ID on flush and reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global run enable; 0 freezes all state.
- stall  in  1  hold PC and IF/ID this cycle.
- redirect  in  1  taken branch/jump; load redirect_pc and flush IF/ID.
- redirect_pc  in  PC_W  target word index.
- mem_pc  out  PC_W  word index driven to code memory (= pc_reg).
- mem_instr  in  32  instruction returned combinationally from code memory, same cycle.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  PC_W  PC of id_instr.
- id_valid  out  1  1 = id_instr is a real fetched instruction; 0 = bubble.
- fetch_count  out  32  number of instructions delivered to ID.

Behaviour:
- Reset (async, immediate, even mid-operation):
  - pc_reg=RESET_PC, id_instr=NOP_INSTR, id_pc=0, id_valid=0, fetch_count=0.
  - First valid id_instr appears on the first enabled non-stalled edge after reset release.
- mem_pc is combinational from pc_reg. There is zero memory latency: mem_instr is sampled on the same edge that advances the PC.
- Per rising edge, priority order:
  1. en=0: hold everything. redirect and stall are ignored.
  2. redirect=1: pc_reg <= redirect_pc & (MEM_DEPTH-1). id_instr <= NOP_INSTR, id_pc <= 0, id_valid <= 0. fetch_count unchanged. Redirect overrides a simultaneous stall.
  3. stall=1: pc_reg, id_instr, id_pc, id_valid and fetch_count all hold.
  4. Otherwise (advance):
     - id_instr <= mem_instr, id_pc <= pc_reg, id_valid <= 1.
     - pc_reg <= (pc_reg+1) & (MEM_DEPTH-1).
     - fetch_count <= fetch_count+1.
- Wrap-around:
  - pc_reg=MEM_DEPTH-1 advances to 0.
  - Out-of-range redirect_pc is masked to its low log2(MEM_DEPTH) bits.
  - PC bits above log2(MEM_DEPTH) are always 0.
  - fetch_count wraps 2^32-1 -> 0.
- Redirect penalty: exactly one bubble. The cycle after redirect, ID holds a bubble and mem_pc = target. The next advance delivers the target instruction.
- A fetched NOP_INSTR word (e.g. zero-filled memory) counts as valid: id_valid=1 and fetch_count increments. Bubble detection uses id_valid, not the encoding.
- Back-to-back redirects: each is honoured and id_valid stays 0 throughout.
- Stall held for N cycles: IF/ID is bit-stable for all N cycles.

Decomposition:
- Shared package/def file holds: NOP_INSTR encoding, RESET_PC, MEM_DEPTH, derived index width (log2), and instruction field positions (opcode[31:26], rs[25:21], rt[20:16], rd[15:11]).
- The same package is used by the decoder and the code memory.
- One sub-module, if_id_reg: the IF/ID register with load/hold/flush controls and reset-to-bubble. instr_fetch instantiates it and keeps the PC, priority logic and counter at top level.

Test Plan:
- Reset, memory words 0..3 = 0x44200001, 0x44400002, 0x44600003, 0x44800004, en=1, 4 edges -> id_pc 0,1,2,3 with matching id_instr, id_valid=1 from edge 1, fetch_count=4.
- Stall high 3 cycles at pc_reg=5 -> mem_pc=5 and id_pc=4 constant for 3 cycles, fetch_count unchanged; release -> id_pc=5.
- Redirect to 12 with stall also high at pc_reg=7 -> next cycle id_valid=0, id_instr=0, mem_pc=12; following edge -> id_pc=12, id_valid=1.
- redirect_pc=0x1FE with MEM_DEPTH=256 -> mem_pc=0xFE; two advances -> id_pc 0xFE, 0xFF, then mem_pc=0.
- en=0 with redirect=1 for 2 cycles -> all outputs unchanged.
- Assert rst asynchronously mid-cycle after 10 fetches -> outputs clear before the next edge: id_valid=0, fetch_count=0, mem_pc=0.
